// File: rtl/bandai_unlock_host.sv
// bandai_unlock_host: console-side unlock handshake for the cartridge mapper.
// Pulses CART_RSTn, drives the 5Ah/A5h unlock addresses, captures the
// mapper's serial frame on SI and raises CTRL1_B7 when the payload matches.
// Optional build macro: HANDSHAKE_RETRY_EN (retries a failed handshake with
// a fresh cartridge reset, up to RETRIES extra attempts).
module bandai_unlock_host #(
  parameter int          RST_CYCLES  = 4,
  parameter int          HUNT_MAX    = 8,
  parameter logic [15:0] EXPECT_WORD = 16'h28A0,
  parameter logic [7:0]  IDLE_ADDR   = 8'h00,
  parameter int          RETRIES     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        SI,
  output logic        CART_RSTn,
  output logic [7:0]  ADDR,
  output logic        ADDR_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  ERR,
  output logic [15:0] WORD,
  output logic        CTRL1_B7
);

  localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam int HW = (HUNT_MAX < 2) ? 1 : $clog2(HUNT_MAX + 1);

  localparam logic [7:0] ACK_ADDR = 8'h5A;
  localparam logic [7:0] NAK_ADDR = 8'hA5;

  // Reject configurations that cannot produce a valid unlock sequence.
  if (RST_CYCLES < 1 || HUNT_MAX < 1 || RETRIES < 0 ||
      IDLE_ADDR == 8'h5A || IDLE_ADDR == 8'hA5) begin : g_cfg_check
    $error("bandai_unlock_host: illegal parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_RESET, S_SETTLE, S_ACK, S_NAK, S_HUNT, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t          state, nxt;
  logic [RW-1:0]   rst_cnt;
  logic [HW-1:0]   hunt_cnt;
  logic [3:0]      bit_cnt;
  logic [15:0]     work;
  logic            start_acc;
  logic            fail;
  logic [1:0]      fail_code;
  logic            pass;

`ifdef HANDSHAKE_RETRY_EN
  localparam int AW = (RETRIES < 2) ? 1 : $clog2(RETRIES + 1);
  logic [AW-1:0]   attempts;
  logic            retry;
`endif

  // Next-state decode: sequencing, HUNT timeout and STOP-bit verdict.
  always_comb begin
    nxt       = state;
    start_acc = 1'b0;
    fail      = 1'b0;
    fail_code = 2'd0;
    pass      = 1'b0;
`ifdef HANDSHAKE_RETRY_EN
    retry     = 1'b0;
`endif
    case (state)
      S_IDLE:   if (START) begin nxt = S_RESET; start_acc = 1'b1; end
      S_RESET:  if (rst_cnt == RW'(RST_CYCLES - 1)) nxt = S_SETTLE;
      S_SETTLE: nxt = S_ACK;
      S_ACK:    nxt = S_NAK;
      S_NAK:    nxt = S_HUNT;
      S_HUNT: begin
        if (!SI) begin
          nxt = S_DATA;
        end else if (hunt_cnt == HW'(HUNT_MAX - 1)) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end
      end
      S_DATA:   if (bit_cnt == 4'd15) nxt = S_STOP;
      S_STOP: begin
        if (SI) begin
          fail      = 1'b1;
          fail_code = 2'd2;
        end else if (work != EXPECT_WORD) begin
          fail      = 1'b1;
          fail_code = 2'd3;
        end else begin
          pass = 1'b1;
          nxt  = S_DONE;
        end
      end
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (fail) begin
      nxt = S_DONE;
`ifdef HANDSHAKE_RETRY_EN
      if (attempts < AW'(RETRIES)) begin
        nxt   = S_RESET;
        retry = 1'b1;
      end
`endif
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  // Registered outputs and saturating counters, all derived from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CART_RSTn <= 1'b0;
      ADDR      <= IDLE_ADDR;
      ADDR_OE   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 2'd0;
      WORD      <= 16'h0000;
      CTRL1_B7  <= 1'b0;
      rst_cnt   <= '0;
      hunt_cnt  <= '0;
      bit_cnt   <= 4'd0;
    end else begin
      if (nxt == S_RESET)       CART_RSTn <= 1'b0;
      else if (nxt == S_SETTLE) CART_RSTn <= 1'b1;

      ADDR    <= (nxt == S_ACK) ? ACK_ADDR : (nxt == S_NAK) ? NAK_ADDR : IDLE_ADDR;
      ADDR_OE <= (nxt == S_SETTLE) || (nxt == S_ACK) || (nxt == S_NAK) ||
                 (nxt == S_HUNT) || (nxt == S_DATA) || (nxt == S_STOP);
      BUSY    <= (nxt == S_RESET) || (nxt == S_SETTLE) || (nxt == S_ACK) ||
                 (nxt == S_NAK) || (nxt == S_HUNT) || (nxt == S_DATA) || (nxt == S_STOP);
      DONE    <= (nxt == S_DONE);

      if (start_acc) begin
        ERR      <= 2'd0;
        CTRL1_B7 <= 1'b0;
      end
      if (fail) ERR <= fail_code;
      if (pass) begin
        ERR      <= 2'd0;
        CTRL1_B7 <= 1'b1;
      end
      if (state == S_STOP) WORD <= work;

      rst_cnt <= (state == S_RESET && nxt == S_RESET) ? rst_cnt + RW'(1) : '0;

      if (state != S_HUNT)                 hunt_cnt <= '0;
      else if (hunt_cnt != HW'(HUNT_MAX))  hunt_cnt <= hunt_cnt + HW'(1);

      if (state != S_DATA)                 bit_cnt <= 4'd0;
      else if (bit_cnt != 4'd15)           bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Frame shift register: LSB arrives first, so shift in from the top.
  always_ff @(posedge CLK) begin
    if (state == S_DATA) work <= {SI, work[15:1]};
  end

`ifdef HANDSHAKE_RETRY_EN
  // Attempt counter for the retry path; cleared on every accepted START.
  always_ff @(posedge CLK) begin
    if (RST)            attempts <= '0;
    else if (start_acc) attempts <= '0;
    else if (retry)     attempts <= attempts + AW'(1);
  end
`endif

endmodule
